// File: rtl/ps2_poly_note_decoder.sv
// PS/2 scancode stream -> polyphonic voice gates/notes plus octave and amplitude registers.
// Optional build macro SUSTAIN_PEDAL_EN turns the space bar (0x29) into a sustain pedal.
module ps2_poly_note_decoder #(
    parameter int NUM_VOICES  = 4,
    parameter int OCT_BITS    = 3,
    parameter int OCT_DEFAULT = 4,
    parameter int OCT_MAX     = 7,
    parameter int AMP_BITS    = 4,
    parameter int AMP_DEFAULT = 8,
    localparam int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [OCT_BITS-1:0]     octave,
    output logic [AMP_BITS-1:0]     amp,
    output logic                    event_valid,
    output logic                    event_on,
    output logic [VIDX_W-1:0]       event_voice,
    output logic                    overflow
);
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t              state;
    logic [15:0]         held;
    logic [4:0]          key;
    logic [3:0]          kidx;
    logic                is_prefix;
    logic                make_now;
    logic                brk_now;
    logic                free_found;
    logic                match_found;
    logic [VIDX_W-1:0]   free_slot;
    logic [VIDX_W-1:0]   match_slot;

    // {hit, index}: indices 0..11 are notes, 12..15 are octave-/octave+/amp-/amp+
    function automatic logic [4:0] decode_key(input logic [7:0] b);
        case (b)
            8'h1C:   decode_key = {1'b1, 4'd0};
            8'h1D:   decode_key = {1'b1, 4'd1};
            8'h1B:   decode_key = {1'b1, 4'd2};
            8'h24:   decode_key = {1'b1, 4'd3};
            8'h23:   decode_key = {1'b1, 4'd4};
            8'h2B:   decode_key = {1'b1, 4'd5};
            8'h2C:   decode_key = {1'b1, 4'd6};
            8'h34:   decode_key = {1'b1, 4'd7};
            8'h35:   decode_key = {1'b1, 4'd8};
            8'h33:   decode_key = {1'b1, 4'd9};
            8'h3C:   decode_key = {1'b1, 4'd10};
            8'h3B:   decode_key = {1'b1, 4'd11};
            8'h1A:   decode_key = {1'b1, 4'd12};
            8'h22:   decode_key = {1'b1, 4'd13};
            8'h16:   decode_key = {1'b1, 4'd14};
            8'h1E:   decode_key = {1'b1, 4'd15};
            default: decode_key = '0;
        endcase
    endfunction

    assign key       = decode_key(byte_data);
    assign kidx      = key[3:0];
    assign is_prefix = (byte_data == 8'hE0) || (byte_data == 8'hF0);
    assign make_now  = byte_valid && (state == S_IDLE) && !is_prefix;
    assign brk_now   = byte_valid && (state == S_BRK) && !is_prefix;

    // A note is never gated in two slots at once, so the first match is the only one.
    always_comb begin
        free_found  = 1'b0;
        free_slot   = '0;
        match_found = 1'b0;
        match_slot  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!free_found && !voice_gate[i]) begin
                free_found = 1'b1;
                free_slot  = VIDX_W'(i);
            end
            if (!match_found && voice_gate[i] && (voice_note[4*i +: 4] == kidx)) begin
                match_found = 1'b1;
                match_slot  = VIDX_W'(i);
            end
        end
    end

`ifdef SUSTAIN_PEDAL_EN
    logic                  sustain;
    logic [NUM_VOICES-1:0] pending;
    logic                  rel_found;
    logic [VIDX_W-1:0]     rel_slot;
    logic                  is_space;

    assign is_space = (byte_data == 8'h29);

    always_comb begin
        rel_found = 1'b0;
        rel_slot  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!rel_found && pending[i]) begin
                rel_found = 1'b1;
                rel_slot  = VIDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            held        <= '0;
            voice_note  <= '0;
            voice_gate  <= '0;
            octave      <= OCT_BITS'(OCT_DEFAULT);
            amp         <= AMP_BITS'(AMP_DEFAULT);
            event_valid <= 1'b0;
            event_on    <= 1'b0;
            event_voice <= '0;
            overflow    <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
            sustain     <= 1'b0;
            pending     <= '0;
`endif
        end else begin
            event_valid <= 1'b0;
            overflow    <= 1'b0;

            if (byte_valid) begin
                case (state)
                    S_IDLE: begin
                        if (byte_data == 8'hE0)      state <= S_EXT;
                        else if (byte_data == 8'hF0) state <= S_BRK;
                    end
                    S_EXT: begin
                        if (byte_data == 8'hF0)      state <= S_EXT_BRK;
                        else if (byte_data != 8'hE0) state <= S_IDLE;
                    end
                    default: begin
                        if (!is_prefix) state <= S_IDLE;
                    end
                endcase
            end

            if (make_now && key[4] && !held[kidx]) begin
                if (kidx < 4'd12) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (match_found && pending[match_slot]) begin
                        pending[match_slot] <= 1'b0;
                        held[kidx]          <= 1'b1;
                        event_valid         <= 1'b1;
                        event_on            <= 1'b1;
                        event_voice         <= match_slot;
                    end else
`endif
                    if (free_found) begin
                        voice_note[4*free_slot +: 4] <= kidx;
                        voice_gate[free_slot]        <= 1'b1;
                        held[kidx]                   <= 1'b1;
                        event_valid                  <= 1'b1;
                        event_on                     <= 1'b1;
                        event_voice                  <= free_slot;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    held[kidx] <= 1'b1;
                    case (kidx[1:0])
                        2'd0:    if (octave != '0) octave <= octave - OCT_BITS'(1);
                        2'd1:    if (octave < OCT_BITS'(OCT_MAX)) octave <= octave + OCT_BITS'(1);
                        2'd2:    if (amp != '0) amp <= amp - AMP_BITS'(1);
                        default: if (amp != '1) amp <= amp + AMP_BITS'(1);
                    endcase
                end
            end

            // Breaks of keys never registered as held (e.g. dropped on overflow) do nothing.
            if (brk_now && key[4] && held[kidx]) begin
                held[kidx] <= 1'b0;
                if ((kidx < 4'd12) && match_found) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (sustain) pending[match_slot] <= 1'b1;
                    else
`endif
                    begin
                        voice_gate[match_slot] <= 1'b0;
                        event_valid            <= 1'b1;
                        event_on               <= 1'b0;
                        event_voice            <= match_slot;
                    end
                end
            end

`ifdef SUSTAIN_PEDAL_EN
            if (make_now && is_space) sustain <= 1'b1;
            if (brk_now && is_space)  sustain <= 1'b0;
            // Pending releases drain only in byte-free cycles so they never collide with byte events.
            if (!byte_valid && !sustain && rel_found) begin
                pending[rel_slot]    <= 1'b0;
                voice_gate[rel_slot] <= 1'b0;
                event_valid          <= 1'b1;
                event_on             <= 1'b0;
                event_voice          <= rel_slot;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ps2_poly_note_decoder.sv
// Directed self-checking bench for ps2_poly_note_decoder (NUM_VOICES=4, default octave/amp settings).
module tb_ps2_poly_note_decoder;
    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] voice_note;
    logic [3:0]  voice_gate;
    logic [2:0]  octave;
    logic [3:0]  amp;
    logic        event_valid;
    logic        event_on;
    logic [1:0]  event_voice;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int ov_cnt = 0;

    ps2_poly_note_decoder #(
        .NUM_VOICES(4), .OCT_BITS(3), .OCT_DEFAULT(4), .OCT_MAX(7), .AMP_BITS(4), .AMP_DEFAULT(8)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .voice_note(voice_note), .voice_gate(voice_gate), .octave(octave), .amp(amp),
        .event_valid(event_valid), .event_on(event_on), .event_voice(event_voice),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (event_valid) ev_cnt++;
        if (overflow) ov_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (voice_gate !== 4'h0) begin errors++; $display("FAIL rst_gate got %h exp 0", voice_gate); end
        checks++; if (voice_note !== 16'h0) begin errors++; $display("FAIL rst_note got %h exp 0", voice_note); end
        checks++; if (octave !== 3'd4) begin errors++; $display("FAIL rst_octave got %0d exp 4", octave); end
        checks++; if (amp !== 4'd8) begin errors++; $display("FAIL rst_amp got %0d exp 8", amp); end
        checks++; if (event_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_pulses got ev=%b ov=%b exp 0 0", event_valid, overflow); end
        reset = 1'b0;
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL mk_gate got %b exp 0001", voice_gate); end
        checks++; if (voice_note[3:0] !== 4'd0) begin errors++; $display("FAIL mk_note got %0d exp 0", voice_note[3:0]); end
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1100) begin errors++; $display("FAIL mk_event got v=%b on=%b slot=%0d exp 1 1 0", event_valid, event_on, event_voice); end
        @(negedge clk);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL mk_pulse_end got %b exp 0", event_valid); end
        send_byte(8'hF0);
        checks++; if (event_valid !== 1'b0 || voice_gate !== 4'b0001) begin errors++; $display("FAIL f0_only got ev=%b gate=%b exp 0 0001", event_valid, voice_gate); end
        send_byte(8'h1C);
        checks++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL brk_gate got %b exp 0000", voice_gate); end
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1000) begin errors++; $display("FAIL brk_event got v=%b on=%b slot=%0d exp 1 0 0", event_valid, event_on, event_voice); end
        checks++; if (voice_note[3:0] !== 4'd0) begin errors++; $display("FAIL brk_note_kept got %0d exp 0", voice_note[3:0]); end
    endtask

    task automatic test_typematic();
        int e0;
        settle();
        e0 = ev_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        settle();
        checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL typ_on_count got %0d exp 1", ev_cnt - e0); end
        checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL typ_gate got %b exp 0001", voice_gate); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        checks++; if (ev_cnt - e0 !== 2) begin errors++; $display("FAIL typ_off_count got %0d exp 2", ev_cnt - e0); end
        checks++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL typ_gate_off got %b exp 0000", voice_gate); end
    endtask

    task automatic test_alloc_overflow();
        int e0;
        int o0;
        pulse_reset();
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'h23);
        send_byte(8'h2B);
        checks++; if (voice_gate !== 4'hF) begin errors++; $display("FAIL alloc_gate got %b exp 1111", voice_gate); end
        checks++; if (voice_note !== 16'h5420) begin errors++; $display("FAIL alloc_notes got %h exp 5420", voice_note); end
        checks++; if (event_voice !== 2'd3 || event_valid !== 1'b1) begin errors++; $display("FAIL alloc_slot3 got v=%b slot=%0d exp 1 3", event_valid, event_voice); end
        settle();
        e0 = ev_cnt;
        o0 = ov_cnt;
        send_byte(8'h34);
        checks++; if (overflow !== 1'b1 || event_valid !== 1'b0) begin errors++; $display("FAIL ovf_pulse got ov=%b ev=%b exp 1 0", overflow, event_valid); end
        checks++; if (voice_gate !== 4'hF || voice_note !== 16'h5420) begin errors++; $display("FAIL ovf_state got gate=%b note=%h exp 1111 5420", voice_gate, voice_note); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_end got %b exp 0", overflow); end
        send_byte(8'hF0);
        send_byte(8'h34);
        settle();
        checks++; if (ev_cnt - e0 !== 0 || ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_break got ev=%0d ov=%0d exp 0 1", ev_cnt - e0, ov_cnt - o0); end
        send_byte(8'hF0);
        send_byte(8'h1B);
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1001 || voice_gate !== 4'b1101) begin errors++; $display("FAIL free_slot1 got v=%b on=%b slot=%0d gate=%b exp 1 0 1 1101", event_valid, event_on, event_voice, voice_gate); end
        send_byte(8'h33);
        checks++; if (voice_note !== 16'h5490 || event_voice !== 2'd1 || voice_gate !== 4'hF) begin errors++; $display("FAIL reuse_slot1 got note=%h slot=%0d gate=%b exp 5490 1 1111", voice_note, event_voice, voice_gate); end
    endtask

    task automatic test_controls();
        logic [2:0] oct_exp [6];
        logic [3:0] amp_exp [10];
        oct_exp = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        amp_exp = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h1A);
            send_byte(8'hF0);
            send_byte(8'h1A);
            checks++; if (octave !== oct_exp[i]) begin errors++; $display("FAIL oct_down[%0d] got %0d exp %0d", i, octave, oct_exp[i]); end
        end
        send_byte(8'h22);
        checks++; if (octave !== 3'd1) begin errors++; $display("FAIL oct_up got %0d exp 1", octave); end
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h1E);
            send_byte(8'hF0);
            send_byte(8'h1E);
            checks++; if (amp !== amp_exp[i]) begin errors++; $display("FAIL amp_up[%0d] got %0d exp %0d", i, amp, amp_exp[i]); end
        end
        send_byte(8'h16);
        send_byte(8'h16);
        checks++; if (amp !== 4'd14) begin errors++; $display("FAIL amp_typematic got %0d exp 14", amp); end
    endtask

    task automatic test_prefix();
        int e0;
        pulse_reset();
        settle();
        e0 = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        checks++; if (ev_cnt - e0 !== 0 || voice_gate !== 4'h0) begin errors++; $display("FAIL ext_discard got ev=%0d gate=%b exp 0 0000", ev_cnt - e0, voice_gate); end
        send_byte(8'h1C);
        checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL ext_return_idle got %b exp 0001", voice_gate); end
        send_byte(8'hF0);
        pulse_reset();
        checks++; if (voice_gate !== 4'h0 || event_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got gate=%b ev=%b exp 0000 0", voice_gate, event_valid); end
        send_byte(8'h1C);
        checks++; if (voice_gate !== 4'b0001 || event_on !== 1'b1) begin errors++; $display("FAIL post_reset_make got gate=%b on=%b exp 0001 1", voice_gate, event_on); end
    endtask

    task automatic test_back_to_back();
        int e0;
        pulse_reset();
        settle();
        e0 = ev_cnt;
        @(negedge clk); byte_valid = 1'b1; byte_data = 8'h1C;
        @(negedge clk); byte_data = 8'h1B;
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1100) begin errors++; $display("FAIL b2b_first got v=%b on=%b slot=%0d exp 1 1 0", event_valid, event_on, event_voice); end
        @(negedge clk); byte_data = 8'hF0;
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1101) begin errors++; $display("FAIL b2b_second got v=%b on=%b slot=%0d exp 1 1 1", event_valid, event_on, event_voice); end
        @(negedge clk); byte_data = 8'h1C;
        @(negedge clk); byte_valid = 1'b0;
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1000 || voice_gate !== 4'b0010) begin errors++; $display("FAIL b2b_break got v=%b on=%b slot=%0d gate=%b exp 1 0 0 0010", event_valid, event_on, event_voice, voice_gate); end
        settle();
        checks++; if (ev_cnt - e0 !== 3 || voice_note[7:4] !== 4'd2) begin errors++; $display("FAIL b2b_total got ev=%0d note1=%0d exp 3 2", ev_cnt - e0, voice_note[7:4]); end
    endtask

`ifdef SUSTAIN_PEDAL_EN
    task automatic test_sustain();
        pulse_reset();
        send_byte(8'h29);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++; if (voice_gate !== 4'b0001 || event_valid !== 1'b0) begin errors++; $display("FAIL sus_hold got gate=%b ev=%b exp 0001 0", voice_gate, event_valid); end
        send_byte(8'hF0);
        send_byte(8'h29);
        checks++; if (voice_gate !== 4'b0001 || event_valid !== 1'b0) begin errors++; $display("FAIL sus_release_lat got gate=%b ev=%b exp 0001 0", voice_gate, event_valid); end
        @(negedge clk);
        checks++; if ({event_valid, event_on, event_voice} !== 4'b1000 || voice_gate !== 4'b0000) begin errors++; $display("FAIL sus_release got v=%b on=%b slot=%0d gate=%b exp 1 0 0 0000", event_valid, event_on, event_voice, voice_gate); end
    endtask
`else
    task automatic test_space_ignored();
        int e0;
        pulse_reset();
        settle();
        e0 = ev_cnt;
        send_byte(8'h29);
        send_byte(8'h15);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        checks++; if (ev_cnt - e0 !== 2 || voice_gate !== 4'h0) begin errors++; $display("FAIL unknown_keys got ev=%0d gate=%b exp 2 0000", ev_cnt - e0, voice_gate); end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_make_break();
        test_typematic();
        test_alloc_overflow();
        test_controls();
        test_prefix();
        test_back_to_back();
`ifdef SUSTAIN_PEDAL_EN
        test_sustain();
`else
        test_space_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_poly_note_decoder.md
Name: ps2_poly_note_decoder

Overview:
Converts the PS/2 byte stream into polyphonic note events and control registers for the synth core. Tracks make/break (F0) and extended (E0) prefixes, so key releases are seen. Allocates up to NUM_VOICES simultaneous notes to voice slots. Owns saturating octave and amplitude registers with typematic-repeat suppression. Sits between the PS/2 receiver (byte + strobe) and the voice/oscillator bank.

Parameters:
NUM_VOICES, 4, number of voice slots (1..8); VIDX_W = max(1, clog2(NUM_VOICES)) derived locally
OCT_BITS, 3, octave register width
OCT_DEFAULT, 4, octave reset value
OCT_MAX, 7, octave upper saturation bound (lower bound 0)
AMP_BITS, 4, amplitude register width
AMP_DEFAULT, 8, amplitude reset value (saturates at 0 and 2^AMP_BITS-1)

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
byte_valid  in  1  one-cycle strobe, byte_data is valid
byte_data  in  8  received PS/2 scancode byte
voice_note  out  4*NUM_VOICES  note index 0..11 per slot, slot i at [4i+3:4i]
voice_gate  out  NUM_VOICES  1 = slot i sounding
octave  out  OCT_BITS  current octave
amp  out  AMP_BITS  current amplitude
event_valid  out  1  one-cycle pulse: voice gate changed
event_on  out  1  with event_valid: 1 = note on, 0 = note off
event_voice  out  VIDX_W  slot index of the event
overflow  out  1  one-cycle pulse: note make dropped, no free slot

Behaviour:
- Reset values: voice_note all 0, voice_gate 0, octave=OCT_DEFAULT, amp=AMP_DEFAULT, event_* 0, overflow 0, prefix FSM IDLE, held bitmap 0.
- Prefix FSM (advances only on byte_valid): IDLE --E0--> EXT; IDLE --F0--> BRK; EXT --F0--> EXT_BRK; any other byte in IDLE = make, in BRK = break, then IDLE; any non-prefix byte in EXT/EXT_BRK is discarded, then IDLE. E0 in BRK/EXT_BRK or F0 in BRK: stay, no action.
- Note keys: a=1C C, w=1D C#, s=1B D, e=24 D#, d=23 E, f=2B F, t=2C F#, g=34 G, y=35 G#, h=33 A, u=3C A#, j=3B B -> indices 0..11.
- Control keys: z=1A octave-1, x=22 octave+1, 1=16 amp-1, 2=1E amp+1. Act on make only, saturate (octave 0..OCT_MAX, amp 0..max).
- Held bitmap (16 bits: 12 notes + 4 controls): make of a key already held is typematic repeat -> ignored entirely. Break clears its bit.
- Note make, key not held: lowest-index slot with gate=0 gets note, gate=1; event_valid=1, event_on=1, event_voice=slot; held bit set. No free slot: state unchanged, overflow=1, held bit NOT set (its later break is ignored).
- Note break: slot with gate=1 and matching note cleared; event_valid=1, event_on=0; voice_note retains value. No match: no event.
- Unknown scancodes: ignored.
- Latency: all outputs registered, update on the edge after the byte_valid cycle (1 cycle). Back-to-back byte_valid every cycle supported; one byte fully processed per cycle.
- event_valid and overflow are never asserted together; both deassert the next cycle absent a new byte.
- Reset asserted mid-sequence (e.g. after F0): pending prefix discarded, all voices released without events.

Optional Feature:
SUSTAIN_PEDAL_EN: space (29) acts as sustain pedal. While space held, note breaks clear held bits but voices keep gate=1 and are marked pending-release; space break releases all pending slots, one per cycle in ascending index, each with an event_valid/event_on=0 pulse; a new make of a pending note retriggers its slot (event_on=1, pending cleared). Without the macro, 29 is an unknown scancode and ignored.

Test Plan:
- Reset, then bytes 1C -> slot0 gate=1, voice_note[3:0]=0, event_on=1, event_voice=0; then F0,1C -> gate[0]=0, event_on=0 event_voice=0.
- 1C,1C,1C (typematic) -> exactly one event; then F0,1C -> one off event.
- NUM_VOICES=4: makes 1C,1B,23,2B,34 -> slots 0..3 notes 0,2,4,5; fifth gives overflow=1, no gate change; F0,34 -> no event.
- 1A x6 with breaks between each from octave 4 -> 3,2,1,0,0,0; 1E repeated 10x with breaks from amp 8 -> saturates at 15.
- E0,1C then F0,... : E0,1C no event; E0,F0,1C no event; plain F0 followed by reset pulse then 1C -> treated as make.
- With SUSTAIN_PEDAL_EN: 29,1C,F0,1C -> gate[0] stays 1; F0,29 -> gate[0]=0 with off event one cycle later.
